// File: rtl/riscuinho_uart_pkg.sv
// Shared types and constants for the riscuinho RS232 peripheral.
// RS232_ADDR is also used by the core's address decode.
package riscuinho_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [31:0] RS232_ADDR  = 32'h8000_0000;
    localparam int          DEFAULT_DIV = 868;

endpackage

// File: rtl/riscuinho_sync_fifo.sv
// Single-clock show-ahead FIFO: the head is visible on data_o whenever not empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module riscuinho_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/riscuinho_uart.sv
// RS232 peripheral at RS232_ADDR: TX FIFO + 8N1 serializer, 8N1 deserializer + RX FIFO.
// RX head is presented combinationally so the core can read it in its single MEM cycle.
module riscuinho_uart
    import riscuinho_uart_pkg::*;
#(
    parameter int DIV   = DEFAULT_DIV,
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       txd,
    input  logic       rxd,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    output logic       irq
);
    localparam int             CW   = $clog2(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]  HALF = CW'(DIV / 2 - 1);

    // ---------------- TX path ----------------
    uart_state_t   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [7:0]    tx_head;
    logic          tx_pop, tx_empty;

    riscuinho_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (wr_en),
        .data_i  (wr_data),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_cnt_d   = '0;
                    tx_state_d = START;
                end
            end
            START: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // Line level is a pure decode of registered state; the current data bit sits in shift[0].
    assign txd     = (tx_state_q == START) ? 1'b0 :
                     (tx_state_q == DATA)  ? tx_shift_q[0] : 1'b1;
    assign tx_busy = !tx_empty || (tx_state_q != IDLE);

    // ---------------- RX path ----------------
    logic          rx_meta_q, rxs_q;
    uart_state_t   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_push, rx_full, rx_empty, rd_pop;
    logic          rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;

    // Synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    assign rd_pop = rd_en && !rx_empty;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        rx_ovr_d   = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            IDLE: begin
                if (!rxs_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = START;
                end
            end
            START: begin
                if (rx_cnt_q == HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxs_q ? IDLE : DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (rx_cnt_q == LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxs_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (rx_cnt_q == LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = IDLE;
                    if (!rxs_q)                 rx_ferr_d = 1'b1;
                    else if (!rx_full || rd_pop) rx_push  = 1'b1;
                    else                        rx_ovr_d  = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    riscuinho_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rx_push),
        .data_i  (rx_shift_q),
        .pop_i   (rd_en),
        .data_o  (rd_data),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign rd_valid     = !rx_empty;
    assign irq          = !rx_empty;
    assign rx_overrun   = rx_ovr_q;
    assign rx_frame_err = rx_ferr_q;

endmodule

// File: tb/tb_riscuinho_uart.sv
// Scoreboard bench for riscuinho_uart (DIV=8, DEPTH=4): stimulus queues expected bytes,
// a serial TX decoder and an RX read monitor pop and compare them.
module tb_riscuinho_uart;
    localparam int DIV   = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       wr_en = 1'b0, rd_en = 1'b0, rxd_drv = 1'b1, loopback = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid, txd, rxd, tx_full, tx_busy, rx_overrun, rx_frame_err, irq;

    assign rxd = loopback ? txd : rxd_drv;
    always #5 clk = ~clk;

    riscuinho_uart #(.DIV(DIV), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .txd          (txd),
        .rxd          (rxd),
        .tx_full      (tx_full),
        .tx_busy      (tx_busy),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err),
        .irq          (irq)
    );

    int n_cmp = 0, n_bad = 0;
    int rst_cnt = 0, tx_frames = 0;
    int ovr_seen = 0, ferr_seen = 0, exp_ovr = 0, exp_ferr = 0, rx_cnt = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference RX behaviour: good stop bit stores the byte if there is room, else overrun.
    task automatic rx_model_frame(input logic [7:0] b, input bit stop);
        if (!stop)                 exp_ferr++;
        else if (rx_cnt < DEPTH) begin rx_exp.push_back(b); rx_cnt++; end
        else                       exp_ovr++;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        rx_model_frame(b, stop);
        for (int k = 0; k < 10; k++) begin
            rxd_drv = fr[k];
            repeat (DIV) step();
        end
        rxd_drv = 1'b1;
        repeat (2 * DIV) step();
    endtask

    task automatic do_read();
        rd_en = 1'b1;
        if (rx_cnt > 0) rx_cnt--;
        step();
        rd_en = 1'b0;
    endtask

    task automatic loop_byte(input logic [7:0] b);
        loopback = 1'b1;
        tx_exp.push_back(b);
        rx_model_frame(b, 1'b1);
        wr_en = 1'b1; wr_data = b;
        step();
        wr_en = 1'b0;
        repeat (10 * DIV + 20) step();
        loopback = 1'b0;
    endtask

    // Serial TX decoder: samples mid-bit from the first low cycle, aborts if reset intervened.
    logic [9:0] mon_fr;
    int         mon_r0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && txd == 1'b0) begin
                mon_r0 = rst_cnt;
                for (int k = 0; k < 10; k++) begin
                    repeat ((k == 0) ? DIV / 2 : DIV) @(negedge clk);
                    mon_fr[k] = txd;
                end
                if (rst_cnt == mon_r0) begin
                    tx_frames++;
                    check("tx_start_bit", {31'd0, mon_fr[0]}, 32'd0);
                    check("tx_stop_bit", {31'd0, mon_fr[9]}, 32'd1);
                    if (tx_exp.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL tx_extra: got frame %0h, expected none", mon_fr[8:1]);
                    end else begin
                        check("tx_data", {24'd0, mon_fr[8:1]}, {24'd0, tx_exp.pop_front()});
                    end
                end
            end
        end
    end

    // RX monitor: every read strobe is checked against the model's head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_overrun)   ovr_seen++;
            if (rx_frame_err) ferr_seen++;
            if (rd_en) begin
                check("rx_valid_on_read", {31'd0, rd_valid}, {31'd0, rx_exp.size() != 0});
                if (rd_valid && rx_exp.size() != 0)
                    check("rx_data", {24'd0, rd_data}, {24'd0, rx_exp.pop_front()});
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] b;
    logic [9:0] exp_fr;
    int         bad, frames0;

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_tx_full", {31'd0, tx_full}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_pulses", {30'd0, rx_overrun, rx_frame_err}, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (4) step();

        // Single 8'hA5 frame, exact per-cycle txd
        wr_en = 1'b1; wr_data = 8'hA5; tx_exp.push_back(8'hA5);
        step();
        wr_en = 1'b0;
        @(negedge clk);
        check("a5_busy_after_write", {31'd0, tx_busy}, 32'd1);
        exp_fr = {1'b1, 8'hA5, 1'b0};
        bad = 0;
        for (int i = 0; i < 10 * DIV; i++) begin
            @(negedge clk);
            if (txd !== exp_fr[i / DIV]) bad++;
        end
        check("a5_txd_sequence_errs", bad, 0);
        @(negedge clk);
        check("a5_busy_after_frame", {31'd0, tx_busy}, 32'd0);
        repeat (4) step();

        // TX fill: five accepted, sixth dropped while full
        frames0 = tx_frames;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            wr_en = 1'b1; wr_data = b;
            if (i < 5) tx_exp.push_back(b);
            if (i == 5) begin
                @(negedge clk);
                check("fill_tx_full", {31'd0, tx_full}, 32'd1);
            end
            step();
        end
        wr_en = 1'b0;
        repeat (5 * (10 * DIV + 1) + 20) step();
        check("fill_frame_count", tx_frames - frames0, 5);
        check("fill_busy_done", {31'd0, tx_busy}, 32'd0);
        check("fill_full_done", {31'd0, tx_full}, 32'd0);

        // Loopback 8'h3C, then one read drains it
        loop_byte(8'h3C);
        @(negedge clk);
        check("lb_rd_valid", {31'd0, rd_valid}, 32'd1);
        check("lb_rd_data", {24'd0, rd_data}, 32'h3C);
        check("lb_irq", {31'd0, irq}, 32'd1);
        step();
        do_read();
        @(negedge clk);
        check("lb_valid_after_read", {31'd0, rd_valid}, 32'd0);
        check("lb_irq_after_read", {31'd0, irq}, 32'd0);
        step();

        // Overrun: five frames into a four-deep FIFO
        for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
        check("ovr_pulses", ovr_seen, exp_ovr);
        check("ovr_rd_valid", {31'd0, rd_valid}, 32'd1);
        for (int i = 0; i < 4; i++) do_read();
        @(negedge clk);
        check("ovr_drained", {31'd0, rd_valid}, 32'd0);
        step();

        // Frame error, then a short glitch
        send_frame(8'($urandom), 1'b0);
        check("ferr_pulses", ferr_seen, exp_ferr);
        @(negedge clk);
        check("ferr_no_push", {31'd0, rd_valid}, 32'd0);
        check("ferr_rd_data_empty", {24'd0, rd_data}, 32'd0);
        step();
        rxd_drv = 1'b0;
        repeat (2) step();
        rxd_drv = 1'b1;
        repeat (12 * DIV) step();
        check("glitch_no_byte", {31'd0, rd_valid}, 32'd0);
        check("glitch_no_ferr", ferr_seen, exp_ferr);

        // Randomized mix of loopback bytes, direct frames and reads
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 2))
                0: loop_byte(8'($urandom));
                1: send_frame(8'($urandom), $urandom_range(0, 3) != 0);
                default: do_read();
            endcase
        end
        while (rx_cnt > 0) do_read();
        step();
        check("rand_ovr_count", ovr_seen, exp_ovr);
        check("rand_ferr_count", ferr_seen, exp_ferr);

        // Reset mid-TX and mid-RX with data queued in both FIFOs
        send_frame(8'($urandom), 1'b1);
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            step();
        end
        wr_en = 1'b0;
        repeat (20) step();
        rxd_drv = 1'b0;
        repeat (DIV) step();
        for (int k = 0; k < 2; k++) begin
            rxd_drv = 1'($urandom);
            repeat (DIV) step();
        end
        rst_n = 1'b0; rxd_drv = 1'b1; rst_cnt++;
        tx_exp.delete(); rx_exp.delete(); rx_cnt = 0;
        step();
        @(negedge clk);
        check("midrst_txd", {31'd0, txd}, 32'd1);
        check("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("midrst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("midrst_tx_full", {31'd0, tx_full}, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (15 * DIV) step();
        check("postrst_no_rx", {31'd0, rd_valid}, 32'd0);
        check("postrst_tx_idle", {31'd0, tx_busy}, 32'd0);

        // Still functional after reset
        loop_byte(8'($urandom));
        do_read();
        repeat (4) step();

        check("end_tx_exp_left", tx_exp.size(), 0);
        check("end_rx_exp_left", rx_exp.size(), 0);
        check("end_ovr_count", ovr_seen, exp_ovr);
        check("end_ferr_count", ferr_seen, exp_ferr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscuinho_uart.md
# riscuinho_uart

RS232 peripheral that answers the core's byte-wide RS232 port mapped at 32'h80000000. Core-side writes queue bytes into a TX FIFO, which a serializer sends as 8N1 frames on `txd`. A deserializer on `rxd` pushes received bytes into a show-ahead RX FIFO. The core reads that FIFO combinationally in the same cycle it asserts the read strobe. The block sits beside the core in the SoC top and drives the core's `rs232_rd_data` and `rs232_rd_valid` inputs.

## Interface
Parameters:
- `DIV`, 868: clock cycles per bit (100 MHz / 115200). Legal range is 4 and up.
- `DEPTH`, 16: entries per FIFO. Must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  core write strobe. A byte is pushed into the TX FIFO on every cycle it is high.
- `wr_data`  in  8  byte to transmit.
- `rd_en`  in  1  core read strobe. Pops the RX FIFO head at the clock edge.
- `rd_data`  out  8  RX FIFO head. Combinational; 0 when the FIFO is empty.
- `rd_valid`  out  1  RX FIFO not empty. Combinational.
- `txd`  out  1  serial output, idle high.
- `rxd`  in  1  serial input, asynchronous.
- `tx_full`  out  1  TX FIFO full.
- `tx_busy`  out  1  TX FIFO not empty or a frame is in flight.
- `rx_overrun`  out  1  one-cycle pulse: a byte was received while the RX FIFO was full.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `irq`  out  1  equals `rd_valid`. Wired to the core's `irq_lines`.

## Operation
- Reset, with `rst_n` low at a `clk` edge:
  - both FIFOs are emptied;
  - `txd`=1;
  - every other output is 0;
  - both FSMs go to IDLE;
  - all counters are 0.
  - Reset mid-frame aborts the frame immediately; `txd` is high on the next cycle.
- TX push: on `wr_en` && !full the byte is written. On `wr_en` && full the write is dropped silently and FIFO contents are unchanged.
- TX FSM states are IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is not empty, pop the head into `tx_shift` and go to START.
  - START: `txd`=0 for DIV cycles.
  - DATA: 8 bits, LSB first, each held DIV cycles; `bit_cnt` counts 0..7.
  - STOP: `txd`=1 for DIV cycles, then IDLE.
  - Back-to-back frames: the IDLE→START cycle adds one idle-high cycle between frames.
- RX input: `rxd` passes through a 2-flop synchronizer; the FSM sees `rxs`.
- RX FSM states are IDLE, START, DATA, STOP.
  - IDLE: on `rxs`=0 go to START with counter 0.
  - START: at count DIV/2−1 (integer division), check `rxs`. If it is 0, go to DATA with the counter reset. If it is 1, treat it as a glitch and return to IDLE.
  - DATA: sample at every DIV-th cycle, i.e. mid-bit. Shift right with the new bit entering at bit 7. Go to STOP after 8 samples.
  - STOP: sample after DIV cycles.
    - If `rxs`=1 and the FIFO is not full, push the byte.
    - If `rxs`=1 and the FIFO is full, drop the byte and pulse `rx_overrun`.
    - If `rxs`=0, drop the byte and pulse `rx_frame_err`.
    - In all cases go to IDLE. If STOP returns to IDLE while `rxs` is still 0, a new frame begins.
- RX pop: on `rd_en` && !empty the read pointer advances. `rd_en` on an empty FIFO is ignored.
- Simultaneous push and pop on the same FIFO in one cycle are both performed and the count is unchanged. On a full RX FIFO, a pop plus a push in the same cycle succeeds and does not raise overrun.
- FIFO pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.

## Timing
- `wr_en` at edge N gives `tx_busy`=1 after edge N. The first `txd`=0 appears after edge N+1, because the IDLE pop takes one cycle.
- A frame lasts 10·DIV cycles. The next frame starts 1 cycle later.
- `rd_data`/`rd_valid` settle in the same cycle as `rd_en` (zero latency), matching the core's single MEM-cycle read. The pop is visible after that edge.
- The received byte appears at `rd_valid` one cycle after the STOP sample edge.
- Sampling error is at most 3 cycles: 2 synchronizer cycles plus 1 edge-detect cycle.

## Structure
- Package `riscuinho_uart_pkg` holds:
  - `uart_state_t` with IDLE, START, DATA, STOP;
  - `RS232_ADDR` = 32'h80000000, shared with the core's address decode;
  - `DEFAULT_DIV`.
- One sub-module, `riscuinho_sync_fifo`: parameters WIDTH and DEPTH, show-ahead read, with full/empty flags. It is instantiated twice, once for TX and once for RX.

## Test plan
All scenarios use DIV=8 and DEPTH=4.
- Reset, then idle: `txd`=1, `rd_valid`=0, `tx_busy`=0. Write 8'hA5: `txd` sequence is 0,1,0,1,0,0,1,0,1,1, each held 8 cycles, then `tx_busy`=0.
- TX fill: 5 consecutive `wr_en` with 8'h01..8'h05. Item 1 is popped within a cycle, so all 5 are accepted. A 6th write while `tx_full` is dropped. Exactly 5 frames come out, in order.
- RX loopback (`rxd` tied to `txd`): send 8'h3C → `rd_valid`=1 with `rd_data`=8'h3C. A one-cycle `rd_en` gives `rd_valid`=0 and `irq`=0 on the next cycle.
- RX overrun: drive 5 frames with no reads → 4 bytes are kept, the 5th gives a single `rx_overrun` pulse, and a later read returns the first byte.
- Frame error and glitch:
  - A frame with stop bit 0 → one `rx_frame_err` pulse and no push.
  - A 2-cycle low glitch on `rxd` → no byte is received.
- Reset asserted mid-TX and mid-RX frame: `txd`=1 on the next cycle, both FIFOs are empty, and no spurious byte appears afterwards.
